sram_fifo_ctrl: RTL
===================

Name: sram_fifo_ctrl

Overview:
- Synchronous FIFO controller that drives an external rfdp<DEPTH>x<WIDTH> 1W1R SRAM instance.
  - Write side uses the SRAM's port B: AB/DB/CENB.
  - Read side uses port A: AA/CENA/QA.
- Hides the SRAM's 1-cycle read latency behind a 2-entry output skid stage, presenting a first-word-fall-through valid/ready stream at full throughput.
- Sits between JPEG pipeline stages (e.g. line-buffer/MCU reorder, entropy-coder output) wherever a deep elastic buffer is needed.

Parameters:
- DEPTH, 512, SRAM word count; any value >= 2.
- WIDTH, 36, data width.
- AW, $clog2(DEPTH), SRAM address width.

Ports:
- clk  in  1  single clock; also drives the SRAM's CLKA and CLKB externally.
- rstn  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush, active high.
- in_en  in  1  push request.
- in_data  in  WIDTH  push data.
- in_ready  out  1  space available; a push is accepted when in_en & in_ready.
- out_valid  out  1  out_data is valid.
- out_data  out  WIDTH  head entry.
- out_ready  in  1  pop; a pop occurs when out_valid & out_ready.
- fill_cnt  out  AW+2  total entries held.
- ram_ab  out  AW  SRAM write address.
- ram_db  out  WIDTH  SRAM write data.
- ram_cenb  out  1  SRAM write enable, active low.
- ram_aa  out  AW  SRAM read address.
- ram_cena  out  1  SRAM read enable, active low.
- ram_qa  in  WIDTH  SRAM read data; valid in the cycle after ram_cena=0.

Behaviour:
- Reset (rstn=0, async):
  - Cleared to 0: wr_ptr, rd_ptr, sram_cnt, rd_inflight, ostage_cnt, all ostage data.
  - Outputs: out_valid=0, in_ready=1, fill_cnt=0, ram_cena=1, ram_cenb=1, ram_aa=0.
- Write path (combinational):
  - ram_cenb = ~(in_en & in_ready); ram_ab = wr_ptr; ram_db = in_data.
  - On an accepted push, wr_ptr advances.
- Read path (combinational):
  - Define pop = out_valid & out_ready.
  - rd_issue = (sram_cnt != 0) & (ostage_cnt + rd_inflight - pop < 2) & ~clr.
  - ram_cena = ~rd_issue; ram_aa = rd_ptr.
  - On rd_issue, rd_ptr advances; rd_inflight <= rd_issue.
- Pointer wrap: wr_ptr and rd_ptr wrap from DEPTH-1 to 0. This must hold for non-power-of-2 DEPTH (e.g. 12288).
- Counters:
  - sram_cnt (AW+1 bits) increments on push, decrements on rd_issue, unchanged when both occur.
  - in_ready = (sram_cnt < DEPTH). The output skid stage is not counted, so total capacity is DEPTH+2.
- Output skid stage: 2-entry register FIFO.
  - When rd_inflight=1, ram_qa is written into the stage at the end of that cycle.
  - out_data = head entry; out_valid = (ostage_cnt != 0).
  - A simultaneous capture and pop keeps ostage_cnt unchanged, with ordering preserved.
  - The rd_issue rule guarantees the stage never overflows.
- fill_cnt = sram_cnt + rd_inflight + ostage_cnt, registered (reflects state after the edge).
- Latency:
  - A push in cycle 0 into an empty FIFO gives out_valid=1 in cycle 3.
  - Steady state with out_ready=1: one entry in and one out per cycle, no bubbles.
- Collision: a read never targets the address written in the same cycle, because only committed entries (sram_cnt>0) are read. An entry written at cycle t is readable from t+1. No bypass path exists.
- clr (synchronous):
  - Next cycle: all pointers and counts are 0, out_valid=0, in_ready=1.
  - The push and pop in the clr cycle are ignored for state purposes (in_ready still reflects pre-clr state).
  - Any in-flight SRAM read data is discarded.
- Reset mid-operation: state is lost immediately and the outputs take their reset values. SRAM contents are not cleared and are never read before being rewritten.
- No error flags. A push with in_ready=0 or a pop with out_valid=0 is a no-op.

Test Plan:
- Single push of 0x123456789 into an empty FIFO at cycle 0, out_ready=1 → ram_cena=0 at cycle 1 with ram_aa=0; out_valid=1 with out_data=0x123456789 at cycle 3; fill_cnt back to 0 at cycle 4.
- Continuous push of 0..999 with out_ready=1 → output is 0..999 in order. After the initial 3-cycle latency there are no gaps, and fill_cnt stays ≤ 3.
- out_ready=0, push until in_ready drops → exactly DEPTH+2=514 pushes accepted and fill_cnt=514. Then pop all → data 0..513 in order, and ram_aa wraps 511→0.
- Random in_en/out_ready (seeded, 10k cycles) against a scoreboard model → no loss, duplication or reordering. ostage_cnt never exceeds 2; rd_ptr never passes wr_ptr.
- clr asserted with fill_cnt=100 and a read in flight → next cycle fill_cnt=0, out_valid=0. A subsequent push of 0xAA appears alone at out_data three cycles later.
- rstn pulsed low mid-burst (async, not clock-aligned) → outputs go immediately to in_ready=1, out_valid=0, ram_cena=1, ram_cenb=1. After release, normal operation resumes from address 0.

Source files
------------

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller around an external 1W1R SRAM. The write side uses port B
// and the read side uses port A. A 2-entry register stage hides the SRAM read
// latency, so the output is a first-word-fall-through valid/ready stream.
module sram_fifo_ctrl #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 36,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             in_en,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [AW+1:0]    fill_cnt,
    output logic [AW-1:0]    ram_ab,
    output logic [WIDTH-1:0] ram_db,
    output logic             ram_cenb,
    output logic [AW-1:0]    ram_aa,
    output logic             ram_cena,
    input  logic [WIDTH-1:0] ram_qa
);

    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      sram_cnt_q, sram_cnt_d;
    logic             rd_inflight_q, rd_inflight_d;
    logic [1:0]       ostage_cnt_q, ostage_cnt_d;
    logic [WIDTH-1:0] ost0_q, ost0_d;
    logic [WIDTH-1:0] ost1_q, ost1_d;
    logic [AW+1:0]    fill_cnt_q, fill_cnt_d;

    logic       push;
    logic       pop;
    logic       rd_issue;
    logic [2:0] stage_occ;

    // Wrap explicitly at DEPTH-1 so non-power-of-2 depths work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + AW'(1);
    endfunction

    // Handshakes, read issue decision and SRAM port drive.
    // Push is also gated by rstn so both SRAM ports stay idle while reset is held.
    always_comb begin
        in_ready  = (sram_cnt_q < DEPTH_CNT);
        out_valid = (ostage_cnt_q != 2'd0);
        out_data  = ost0_q;
        push      = in_en & in_ready & rstn;
        pop       = out_valid & out_ready;
        stage_occ = {1'b0, ostage_cnt_q} + {2'b00, rd_inflight_q} - {2'b00, pop};
        rd_issue  = (sram_cnt_q != '0) & (stage_occ < 3'd2) & ~clr & rstn;
        ram_cenb  = ~push;
        ram_ab    = wr_ptr_q;
        ram_db    = in_data;
        ram_cena  = ~rd_issue;
        ram_aa    = rd_ptr_q;
        fill_cnt  = fill_cnt_q;
    end

    // Next-state for pointers, counters and the output skid stage.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        sram_cnt_d    = sram_cnt_q;
        rd_inflight_d = rd_issue;
        ostage_cnt_d  = ostage_cnt_q;
        ost0_d        = ost0_q;
        ost1_d        = ost1_q;
        if (clr) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            sram_cnt_d    = '0;
            rd_inflight_d = 1'b0;
            ostage_cnt_d  = '0;
            ost0_d        = '0;
            ost1_d        = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (rd_issue) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, rd_issue})
                2'b10:   sram_cnt_d = sram_cnt_q + (AW+1)'(1);
                2'b01:   sram_cnt_d = sram_cnt_q - (AW+1)'(1);
                default: sram_cnt_d = sram_cnt_q;
            endcase
            // Capture of returning read data vs. pop of the head entry.
            case ({rd_inflight_q, pop})
                2'b10: begin
                    if (ostage_cnt_q == 2'd0) begin
                        ost0_d = ram_qa;
                    end else begin
                        ost1_d = ram_qa;
                    end
                    ostage_cnt_d = ostage_cnt_q + 2'd1;
                end
                2'b01: begin
                    ost0_d       = ost1_q;
                    ostage_cnt_d = ostage_cnt_q - 2'd1;
                end
                2'b11: begin
                    if (ostage_cnt_q == 2'd1) begin
                        ost0_d = ram_qa;
                    end else begin
                        ost0_d = ost1_q;
                        ost1_d = ram_qa;
                    end
                end
                default: ;
            endcase
        end
        fill_cnt_d = (AW+2)'(sram_cnt_d) + (AW+2)'(rd_inflight_d) + (AW+2)'(ostage_cnt_d);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            sram_cnt_q    <= '0;
            rd_inflight_q <= 1'b0;
            ostage_cnt_q  <= '0;
            ost0_q        <= '0;
            ost1_q        <= '0;
            fill_cnt_q    <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            sram_cnt_q    <= sram_cnt_d;
            rd_inflight_q <= rd_inflight_d;
            ostage_cnt_q  <= ostage_cnt_d;
            ost0_q        <= ost0_d;
            ost1_q        <= ost1_d;
            fill_cnt_q    <= fill_cnt_d;
        end
    end

endmodule
